seg7_bcd_display: RTL and testbench

SEG7_BCD_DISPLAY -- requirements
Module: seg7_bcd_display

---
 rtl/seg7_pkg.sv | 34 +++
 rtl/seg7_glyph.sv | 33 +++
 rtl/seg7_bcd_display.sv | 184 ++++++++++++++++++
 tb/tb_seg7_bcd_display.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared types and constants for the BCD / hex seven-segment display block.
package seg7_pkg;

    // Controller states: waiting for a value, running double-dabble, loading outputs.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        UPDATE  = 2'd2
    } state_t;

    // Active-low glyphs, bit order g..a.
    localparam logic [6:0] GLYPH_0     = 7'b1000000;
    localparam logic [6:0] GLYPH_1     = 7'b1111001;
    localparam logic [6:0] GLYPH_2     = 7'b0100100;
    localparam logic [6:0] GLYPH_3     = 7'b0110000;
    localparam logic [6:0] GLYPH_4     = 7'b0011001;
    localparam logic [6:0] GLYPH_5     = 7'b0010010;
    localparam logic [6:0] GLYPH_6     = 7'b0000010;
    localparam logic [6:0] GLYPH_7     = 7'b1111000;
    localparam logic [6:0] GLYPH_8     = 7'b0000000;
    localparam logic [6:0] GLYPH_9     = 7'b0010000;
    localparam logic [6:0] GLYPH_A     = 7'b0001000;
    localparam logic [6:0] GLYPH_B     = 7'b0000011;
    localparam logic [6:0] GLYPH_C     = 7'b1000110;
    localparam logic [6:0] GLYPH_D     = 7'b0100001;
    localparam logic [6:0] GLYPH_E     = 7'b0000110;
    localparam logic [6:0] GLYPH_F     = 7'b0001110;
    localparam logic [6:0] GLYPH_DASH  = 7'b0111111;
    localparam logic [6:0] GLYPH_BLANK = 7'b1111111;

    // Position of the decimal point inside each 8-bit digit slice.
    localparam int DP_BIT = 7;

endpackage

// File: rtl/seg7_glyph.sv
// Combinational nibble-to-glyph decoder, one instance per display digit.
module seg7_glyph
    import seg7_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_glyph
);

    // Look up the active-low segment pattern for the nibble.
    always_comb begin
        o_glyph = GLYPH_BLANK;
        case (i_nibble)
            4'h0:    o_glyph = GLYPH_0;
            4'h1:    o_glyph = GLYPH_1;
            4'h2:    o_glyph = GLYPH_2;
            4'h3:    o_glyph = GLYPH_3;
            4'h4:    o_glyph = GLYPH_4;
            4'h5:    o_glyph = GLYPH_5;
            4'h6:    o_glyph = GLYPH_6;
            4'h7:    o_glyph = GLYPH_7;
            4'h8:    o_glyph = GLYPH_8;
            4'h9:    o_glyph = GLYPH_9;
            4'hA:    o_glyph = GLYPH_A;
            4'hB:    o_glyph = GLYPH_B;
            4'hC:    o_glyph = GLYPH_C;
            4'hD:    o_glyph = GLYPH_D;
            4'hE:    o_glyph = GLYPH_E;
            4'hF:    o_glyph = GLYPH_F;
            default: o_glyph = GLYPH_BLANK;
        endcase
    end

endmodule

// File: rtl/seg7_bcd_display.sv
// Binary-to-seven-segment display driver: decimal via serial double-dabble,
// or hexadecimal directly from the low nibbles, with overflow dashes,
// leading-zero blanking and per-digit decimal points.
module seg7_bcd_display
    import seg7_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int DIGITS = 6
) (
    input  logic                iCLK,
    input  logic                iRST,
    input  logic [WIDTH-1:0]    in_value,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                hex_mode,
    input  logic                blank_en,
    input  logic [DIGITS-1:0]   dp_mask,
    output logic [8*DIGITS-1:0] seg,
    output logic                overflow,
    output logic                done
);

    localparam int BCDW = 4 * DIGITS;
    localparam int EXTW = (WIDTH > BCDW) ? WIDTH : BCDW;
    localparam int CNTW = $clog2(WIDTH + 1);
    localparam logic [CNTW-1:0] CNT_LOAD = CNTW'(WIDTH);
    localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);

    state_t              r_state;
    state_t              w_next;
    logic                r_armed;
    logic [WIDTH-1:0]    r_bin;
    logic [BCDW-1:0]     r_bcd;
    logic [CNTW-1:0]     r_cnt;
    logic                r_ovfWork;
    logic                r_blank;
    logic [DIGITS-1:0]   r_dp;
    logic [8*DIGITS-1:0] r_seg;
    logic                r_ovf;
    logic                r_done;

    logic                w_accept;
    logic [EXTW-1:0]     w_inExt;
    logic                w_hexOvf;
    logic [BCDW-1:0]     w_bcdAdj;
    logic [DIGITS-1:0]   w_blankDig;
    logic [6:0]          w_glyph [DIGITS];
    logic [8*DIGITS-1:0] w_segNext;

    assign in_ready = r_armed && (r_state == IDLE);
    assign w_accept = in_valid && in_ready;
    assign seg      = r_seg;
    assign overflow = r_ovf;
    assign done     = r_done;

    // Widen (or keep) the input so the low nibbles and the bits above them can be sliced safely.
    assign w_inExt  = EXTW'(in_value);
    assign w_hexOvf = (w_inExt >> BCDW) != '0;

    // State register; reset parks the controller in IDLE.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic: hex skips conversion, decimal runs WIDTH double-dabble steps.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next = hex_mode ? UPDATE : CONVERT;
                end
            end
            CONVERT: begin
                if (r_cnt == CNT_ONE) begin
                    w_next = UPDATE;
                end
            end
            UPDATE:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Double-dabble correction: every BCD digit of 5 or more gets 3 added before the shift.
    always_comb begin
        w_bcdAdj = r_bcd;
        for (int d = 0; d < DIGITS; d++) begin
            if (r_bcd[4*d +: 4] >= 4'd5) begin
                w_bcdAdj[4*d +: 4] = r_bcd[4*d +: 4] + 4'd3;
            end
        end
    end

    // Leading-zero blanking: a digit blanks only if it and every digit above it are zero.
    always_comb begin
        logic seenNonZero;
        seenNonZero = 1'b0;
        w_blankDig  = '0;
        for (int d = DIGITS - 1; d >= 0; d--) begin
            if (r_bcd[4*d +: 4] != 4'h0) begin
                seenNonZero = 1'b1;
            end
            w_blankDig[d] = r_blank && !seenNonZero && (d != 0);
        end
    end

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : gen_glyph
            seg7_glyph u_glyph (
                .i_nibble (r_bcd[4*g +: 4]),
                .o_glyph  (w_glyph[g])
            );
        end
    endgenerate

    // Assemble the display word: dashes on overflow, blanks for leading zeros, DP per mask.
    always_comb begin
        w_segNext = '1;
        for (int d = 0; d < DIGITS; d++) begin
            if (r_ovfWork) begin
                w_segNext[8*d +: 7] = GLYPH_DASH;
            end else if (w_blankDig[d]) begin
                w_segNext[8*d +: 7] = GLYPH_BLANK;
            end else begin
                w_segNext[8*d +: 7] = w_glyph[d];
            end
            w_segNext[8*d + DP_BIT] = ~r_dp[d];
        end
    end

    // Datapath: capture on accept, shift during conversion, load visible outputs in UPDATE.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_armed   <= 1'b0;
            r_bin     <= '0;
            r_bcd     <= '0;
            r_cnt     <= '0;
            r_ovfWork <= 1'b0;
            r_blank   <= 1'b0;
            r_dp      <= '0;
            r_seg     <= '1;
            r_ovf     <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_armed <= 1'b1;
            r_done  <= (r_state == UPDATE);
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_blank <= blank_en;
                        r_dp    <= dp_mask;
                        r_cnt   <= CNT_LOAD;
                        if (hex_mode) begin
                            r_bcd     <= w_inExt[BCDW-1:0];
                            r_ovfWork <= w_hexOvf;
                        end else begin
                            r_bin     <= in_value;
                            r_bcd     <= '0;
                            r_ovfWork <= 1'b0;
                        end
                    end
                end
                CONVERT: begin
                    r_bcd     <= {w_bcdAdj[BCDW-2:0], r_bin[WIDTH-1]};
                    r_bin     <= r_bin << 1;
                    r_ovfWork <= r_ovfWork | w_bcdAdj[BCDW-1];
                    r_cnt     <= r_cnt - CNT_ONE;
                end
                UPDATE: begin
                    r_seg <= w_segNext;
                    r_ovf <= r_ovfWork;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seg7_bcd_display.sv
// Self-checking bench for seg7_bcd_display at WIDTH=16, DIGITS=4.
module tb_seg7_bcd_display;

    localparam int WIDTH  = 16;
    localparam int DIGITS = 4;

    logic                iCLK;
    logic                iRST;
    logic [WIDTH-1:0]    in_value;
    logic                in_valid;
    logic                in_ready;
    logic                hex_mode;
    logic                blank_en;
    logic [DIGITS-1:0]   dp_mask;
    logic [8*DIGITS-1:0] seg;
    logic                overflow;
    logic                done;

    int vectorCount = 0;
    int failCount   = 0;
    bit checkEn     = 0;

    // Active-low g..a patterns for 0-F.
    logic [6:0] glyphTab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    seg7_bcd_display #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .iCLK     (iCLK),
        .iRST     (iRST),
        .in_value (in_value),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .hex_mode (hex_mode),
        .blank_en (blank_en),
        .dp_mask  (dp_mask),
        .seg      (seg),
        .overflow (overflow),
        .done     (done)
    );

    // Free-running clock, 10 time units per cycle.
    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    // Record one comparison and report it when it disagrees.
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectorCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: actual=%h required=%h", name, actual, expected);
        end
    endtask

    // What the display must show for a value, from plain digit arithmetic.
    function automatic logic [31:0] modelSeg(input longint v, input bit hex, input bit blank,
                                             input logic [3:0] dp, output bit ovf);
        longint base;
        longint p;
        logic [31:0] r;
        logic [6:0] glyph;
        int dig;
        base = hex ? 16 : 10;
        ovf  = v >= base * base * base * base;
        r    = '1;
        p    = 1;
        for (int i = 0; i < DIGITS; i++) begin
            dig = int'((v / p) % base);
            if (ovf)                          glyph = 7'b0111111;
            else if (blank && i > 0 && v < p) glyph = 7'b1111111;
            else                              glyph = glyphTab[dig];
            r[8*i +: 8] = {~dp[i], glyph};
            p = p * base;
        end
        return r;
    endfunction

    // Latency-based reference: an accepted value appears after a fixed number of edges.
    logic        mReady   = 1'b0;
    logic        mBusy    = 1'b0;
    int          mCount   = 0;
    logic [31:0] mSeg     = '1;
    logic        mOvf     = 1'b0;
    logic        mDone    = 1'b0;
    logic [31:0] pendSeg  = '1;
    bit          pendOvf  = 0;

    always @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            mReady = 1'b0;
            mBusy  = 1'b0;
            mCount = 0;
            mSeg   = '1;
            mOvf   = 1'b0;
            mDone  = 1'b0;
        end else begin
            mDone = 1'b0;
            if (mBusy) begin
                mCount--;
                if (mCount == 0) begin
                    mBusy = 1'b0;
                    mSeg  = pendSeg;
                    mOvf  = pendOvf;
                    mDone = 1'b1;
                end
            end else if (mReady && in_valid) begin
                mBusy   = 1'b1;
                mCount  = hex_mode ? 1 : WIDTH + 1;
                pendSeg = modelSeg(longint'(in_value), hex_mode, blank_en, dp_mask, pendOvf);
            end
            mReady = !mBusy;
        end
    end

    // Every cycle, away from the active edge, the DUT must agree with the reference.
    always @(negedge iCLK) begin
        if (checkEn) begin
            checkOutput("cycle.in_ready", 32'(in_ready), 32'(mReady));
            checkOutput("cycle.done", 32'(done), 32'(mDone));
            checkOutput("cycle.overflow", 32'(overflow), 32'(mOvf));
            checkOutput("cycle.seg", seg, mSeg);
        end
    end

    // Offer one value, wait for done, and pin latency and outputs to hand-computed literals.
    task automatic applyStimulus(input string tag, input logic [15:0] value, input logic hexSel,
                                 input logic blankSel, input logic [3:0] dpSel,
                                 input logic [31:0] expSeg, input logic expOvf, input int expEdges);
        int guard;
        int edges;
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(negedge iCLK);
            guard++;
        end
        checkOutput({tag, ".ready"}, 32'(in_ready), 32'd1);
        in_value = value;
        hex_mode = hexSel;
        blank_en = blankSel;
        dp_mask  = dpSel;
        in_valid = 1'b1;
        @(posedge iCLK);
        @(negedge iCLK);
        in_valid = 1'b0;
        edges = 0;
        while (!done && edges < 100) begin
            @(posedge iCLK);
            edges++;
            @(negedge iCLK);
        end
        checkOutput({tag, ".latency"}, 32'(edges), 32'(expEdges));
        checkOutput({tag, ".seg"}, seg, expSeg);
        checkOutput({tag, ".overflow"}, 32'(overflow), 32'(expOvf));
    endtask

    initial begin
        int guard;
        iRST     = 1'b1;
        in_value = '0;
        in_valid = 1'b0;
        hex_mode = 1'b0;
        blank_en = 1'b0;
        dp_mask  = '0;
        repeat (3) @(posedge iCLK);
        @(negedge iCLK);
        checkEn = 1;
        checkOutput("reset.seg", seg, 32'hFFFF_FFFF);
        checkOutput("reset.in_ready", 32'(in_ready), 32'd0);
        checkOutput("reset.overflow", 32'(overflow), 32'd0);
        iRST = 1'b0;
        #1;
        checkOutput("release.in_ready_low", 32'(in_ready), 32'd0);
        @(negedge iCLK);
        checkOutput("release.in_ready_high", 32'(in_ready), 32'd1);

        applyStimulus("dec1234",   16'd1234,  1'b0, 1'b0, 4'b0000, 32'hF9A4_B099, 1'b0, 17);
        applyStimulus("dec0blank", 16'd0,     1'b0, 1'b1, 4'b0000, 32'hFFFF_FFC0, 1'b0, 17);
        applyStimulus("dec10000",  16'd10000, 1'b0, 1'b0, 4'b0000, 32'hBFBF_BFBF, 1'b1, 17);
        applyStimulus("dec9999",   16'd9999,  1'b0, 1'b0, 4'b0000, 32'h9090_9090, 1'b0, 17);
        applyStimulus("hexBEEF",   16'hBEEF,  1'b1, 1'b0, 4'b0001, 32'h8386_860E, 1'b0, 1);
        applyStimulus("hex42blank",16'h0042,  1'b1, 1'b1, 4'b0000, 32'hFFFF_99A4, 1'b0, 1);
        applyStimulus("dec205",    16'd205,   1'b0, 1'b1, 4'b0100, 32'hFF24_C092, 1'b0, 17);
        applyStimulus("dec65535",  16'd65535, 1'b0, 1'b1, 4'b1000, 32'h3FBF_BFBF, 1'b1, 17);

        // A second offer while converting must be ignored.
        in_value = 16'd1234;
        hex_mode = 1'b0;
        blank_en = 1'b0;
        dp_mask  = 4'b0000;
        in_valid = 1'b1;
        @(posedge iCLK);
        @(negedge iCLK);
        in_valid = 1'b0;
        repeat (4) @(negedge iCLK);
        in_value = 16'd7777;
        in_valid = 1'b1;
        repeat (3) @(negedge iCLK);
        in_valid = 1'b0;
        in_value = '0;
        guard = 0;
        while (!done && guard < 100) begin
            @(negedge iCLK);
            guard++;
        end
        checkOutput("busy.done", 32'(done), 32'd1);
        checkOutput("busy.seg", seg, 32'hF9A4_B099);

        // Reset in the middle of a conversion aborts it.
        @(negedge iCLK);
        in_value = 16'd4321;
        in_valid = 1'b1;
        @(posedge iCLK);
        @(negedge iCLK);
        in_valid = 1'b0;
        repeat (5) @(negedge iCLK);
        #2 iRST = 1'b1;
        #1;
        checkOutput("midreset.seg", seg, 32'hFFFF_FFFF);
        checkOutput("midreset.done", 32'(done), 32'd0);
        checkOutput("midreset.in_ready", 32'(in_ready), 32'd0);
        repeat (2) @(negedge iCLK);
        iRST = 1'b0;
        #1;
        checkOutput("midrelease.in_ready_low", 32'(in_ready), 32'd0);
        @(negedge iCLK);
        checkOutput("midrelease.in_ready_high", 32'(in_ready), 32'd1);
        repeat (20) @(negedge iCLK);
        checkOutput("midrelease.seg_held", seg, 32'hFFFF_FFFF);

        applyStimulus("hexA5", 16'h00A5, 1'b1, 1'b0, 4'b0000, 32'hC0C0_8892, 1'b0, 1);

        repeat (2) @(negedge iCLK);
        checkEn = 0;
        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, failCount);
        $finish;
    end

endmodule
